numlock_btn_debouncer: RTL and testbench

//  Debounces one raw push-button (BtnL or BtnR) and produces clean, single-clock enables.

---
 rtl/numlock_btn_debouncer_pkg.sv | 32 +++
 rtl/numlock_sync2.sv | 22 ++
 rtl/numlock_btn_debouncer.sv | 117 +++++++++++
 tb/tb_numlock_btn_debouncer.sv | 125 ++++++++++++
 4 files changed

// File: rtl/numlock_btn_debouncer_pkg.sv
// Shared definitions for the numlock button debouncer: FSM state encodings and display codes.
package numlock_btn_debouncer_pkg;

  // Debouncer FSM states; encoding 3'd7 is unused and recovers to INI.
  typedef enum logic [2:0] {
    INI     = 3'd0,
    WQ      = 3'd1,
    SCEN_ST = 3'd2,
    WH      = 3'd3,
    MCEN_ST = 3'd4,
    CCR     = 3'd5,
    WFCR    = 3'd6
  } state_t;

  // 4-bit display code per state, shared with the top-level state display.
  function automatic logic [3:0] state_disp(input state_t s);
    logic [3:0] code;
    code = 4'h0;
    case (s)
      INI:     code = 4'h0;
      WQ:      code = 4'h1;
      SCEN_ST: code = 4'h2;
      WH:      code = 4'h3;
      MCEN_ST: code = 4'h4;
      CCR:     code = 4'h5;
      WFCR:    code = 4'h6;
      default: code = 4'hF;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/numlock_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
module numlock_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the async level through two flops; both clear on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/numlock_btn_debouncer.sv
// Push-button debouncer producing debounced level, single-shot, repeat and continuous enables.
module numlock_btn_debouncer
  import numlock_btn_debouncer_pkg::*;
#(
  parameter int unsigned N_DC = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic PB,
  output logic DPB,
  output logic SCEN,
  output logic MCEN,
  output logic CCEN
);

  localparam logic [N_DC-1:0] CNT_MAX = '1;

  logic            pb_s;
  state_t          state;
  state_t          state_next;
  logic [N_DC-1:0] cnt;
  logic [N_DC-1:0] cnt_next;
  logic            dpb_next;
  logic            scen_next;
  logic            mcen_next;
  logic            ccen_next;

  numlock_sync2 u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (PB),
    .q     (pb_s)
  );

  // State, counter and registered Moore outputs (decoded one step early from next state).
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= INI;
      cnt   <= '0;
      DPB   <= 1'b0;
      SCEN  <= 1'b0;
      MCEN  <= 1'b0;
      CCEN  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      DPB   <= dpb_next;
      SCEN  <= scen_next;
      MCEN  <= mcen_next;
      CCEN  <= ccen_next;
    end
  end

  // Next-state and counter logic; any transition defaults the counter to zero.
  always_comb begin
    state_next = INI;
    cnt_next   = '0;
    dpb_next   = 1'b0;
    scen_next  = 1'b0;
    mcen_next  = 1'b0;
    ccen_next  = 1'b0;

    case (state)
      INI: begin
        if (pb_s) state_next = WQ;
      end
      WQ: begin
        if (!pb_s)              state_next = INI;
        else if (cnt == CNT_MAX) state_next = SCEN_ST;
        else begin
          state_next = WQ;
          cnt_next   = cnt + N_DC'(1);
        end
      end
      SCEN_ST: state_next = WH;
      WH, CCR: begin
        if (!pb_s)              state_next = WFCR;
        else if (cnt == CNT_MAX) state_next = MCEN_ST;
        else begin
          state_next = state;
          cnt_next   = cnt + N_DC'(1);
        end
      end
      MCEN_ST: state_next = CCR;
      WFCR: begin
        if (pb_s)                state_next = WFCR;
        else if (cnt == CNT_MAX) state_next = INI;
        else begin
          state_next = WFCR;
          cnt_next   = cnt + N_DC'(1);
        end
      end
      default: state_next = INI;
    endcase

    case (state_next)
      SCEN_ST: begin
        dpb_next  = 1'b1;
        scen_next = 1'b1;
        mcen_next = 1'b1;
        ccen_next = 1'b1;
      end
      WH, CCR: begin
        dpb_next  = 1'b1;
        ccen_next = 1'b1;
      end
      MCEN_ST: begin
        dpb_next  = 1'b1;
        mcen_next = 1'b1;
        ccen_next = 1'b1;
      end
      WFCR:    dpb_next = 1'b1;
      default: dpb_next = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_numlock_btn_debouncer.sv
// Directed bench for numlock_btn_debouncer with a 16-cycle quiet window.
module tb_numlock_btn_debouncer;

  logic clk;
  logic reset;
  logic PB;
  logic DPB;
  logic SCEN;
  logic MCEN;
  logic CCEN;

  int total;
  int passed;
  int failed;

  numlock_btn_debouncer #(.N_DC(4)) dut (
    .clk   (clk),
    .reset (reset),
    .PB    (PB),
    .DPB   (DPB),
    .SCEN  (SCEN),
    .MCEN  (MCEN),
    .CCEN  (CCEN)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one active edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int idx, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s edge=%0d observed=%b expected=%b", tag, idx, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input int idx,
                      input logic d, input logic s, input logic m, input logic c);
    chk({tag, ".DPB"},  idx, DPB,  d);
    chk({tag, ".SCEN"}, idx, SCEN, s);
    chk({tag, ".MCEN"}, idx, MCEN, m);
    chk({tag, ".CCEN"}, idx, CCEN, c);
  endtask

  initial begin
    total  = 0;
    passed = 0;
    failed = 0;
    reset  = 1'b1;
    PB     = 1'b0;
    tick();
    tick();
    chk4("reset", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    tick();
    chk4("idle", 0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Clean press held 60 edges: SCEN at 18, MCEN at 18/35/52.
    PB = 1'b1;
    for (int e = 0; e < 60; e++) begin
      tick();
      chk4("hold", e, e >= 18, e == 18, (e == 18) || (e == 35) || (e == 52), e >= 18);
    end

    // Release: CCEN drops 2 edges after sampling 0, DPB 16 edges after that.
    PB = 1'b0;
    for (int k = 0; k < 22; k++) begin
      tick();
      chk4("release", k, k < 18, 1'b0, 1'b0, k < 2);
    end

    // New press, then release with a one-edge glitch restarting the window.
    PB = 1'b1;
    for (int e = 0; e < 20; e++) begin
      tick();
      chk4("press2", e, e >= 18, e == 18, e == 18, e >= 18);
    end
    for (int k = 0; k < 26; k++) begin
      PB = (k == 5);
      tick();
      chk4("glitch_rel", k, k < 23, 1'b0, 1'b0, k < 2);
    end

    // Bounce: 5 high, 3 low, then held; single SCEN 18 edges after final rise.
    for (int e = 0; e < 31; e++) begin
      PB = !((e >= 5) && (e <= 7));
      tick();
      chk4("bounce", e, e >= 26, e == 26, e == 26, e >= 26);
    end

    // Reset for one edge while in WH with PB still held.
    reset = 1'b1;
    tick();
    chk4("mid_reset", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    for (int f = 0; f < 20; f++) begin
      tick();
      chk4("after_reset", f, f >= 18, f == 18, f == 18, f >= 18);
    end

    // Short press of 10 edges from a fresh idle state never qualifies.
    reset = 1'b1;
    PB    = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    tick();
    for (int e = 0; e < 30; e++) begin
      PB = (e < 10);
      tick();
      chk4("short", e, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
